// File: rtl/dcache_miss_ctrl_if.sv
// Bus bundle between the dcache miss engine and its neighbours: miss intake from the dcache,
// request/response channel to mem_ctrl, fill return path and status flags.
`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 26
`endif
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 512
`endif

interface dcache_miss_ctrl_if #(
    parameter int BLOCK_ADDR_WIDTH = `MAIN_MEM_BLOCK_ADDR_WIDTH,
    parameter int BLOCK_DATA_WIDTH = `BLOCK_DATA_WIDTH
);
    logic                        miss_valid;
    logic [BLOCK_ADDR_WIDTH-1:0] miss_block_addr;
    logic                        victim_dirty;
    logic [BLOCK_ADDR_WIDTH-1:0] victim_block_addr;
    logic [BLOCK_DATA_WIDTH-1:0] victim_block_data;
    logic                        miss_ready;

    logic                        req_valid;
    logic                        req_type;
    logic [BLOCK_ADDR_WIDTH-1:0] req_block_addr;
    logic [BLOCK_DATA_WIDTH-1:0] req_block_data;
    logic                        req_ready;
    logic                        resp_valid;
    logic [BLOCK_DATA_WIDTH-1:0] resp_block_data;

    logic                        fill_valid;
    logic [BLOCK_ADDR_WIDTH-1:0] fill_block_addr;
    logic [BLOCK_DATA_WIDTH-1:0] fill_block_data;
    logic                        busy;
    logic                        err_timeout;
    logic                        err_spurious;

    modport master (
        input  miss_valid, miss_block_addr, victim_dirty, victim_block_addr, victim_block_data,
        input  req_ready, resp_valid, resp_block_data,
        output miss_ready, req_valid, req_type, req_block_addr, req_block_data,
        output fill_valid, fill_block_addr, fill_block_data, busy, err_timeout, err_spurious
    );

    modport slave (
        output miss_valid, miss_block_addr, victim_dirty, victim_block_addr, victim_block_data,
        output req_ready, resp_valid, resp_block_data,
        input  miss_ready, req_valid, req_type, req_block_addr, req_block_data,
        input  fill_valid, fill_block_addr, fill_block_data, busy, err_timeout, err_spurious
    );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Single-outstanding dcache miss engine: optional dirty-victim writeback, refill read,
// then a one-cycle fill pulse back to the dcache arrays.
`ifndef MAIN_MEM_BLOCK_ADDR_WIDTH
`define MAIN_MEM_BLOCK_ADDR_WIDTH 26
`endif
`ifndef BLOCK_DATA_WIDTH
`define BLOCK_DATA_WIDTH 512
`endif

module dcache_miss_ctrl #(
    parameter int BLOCK_ADDR_WIDTH = `MAIN_MEM_BLOCK_ADDR_WIDTH,
    parameter int BLOCK_DATA_WIDTH = `BLOCK_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input logic                clk,
    input logic                rst_aL,
    dcache_miss_ctrl_if.master bus
);
    localparam int               TMR_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WB_REQ  = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_FILL    = 3'd4;

    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    logic [2:0]                  r_state;
    logic [BLOCK_ADDR_WIDTH-1:0] r_miss_addr;
    logic [BLOCK_ADDR_WIDTH-1:0] r_victim_addr;
    logic [BLOCK_DATA_WIDTH-1:0] r_victim_data;
    logic [BLOCK_DATA_WIDTH-1:0] r_resp_data;
    logic [TMR_W-1:0]            r_timer;
    logic                        r_err_timeout;
    logic                        r_err_spurious;

    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state        <= S_IDLE;
            r_miss_addr    <= '0;
            r_victim_addr  <= '0;
            r_victim_data  <= '0;
            r_resp_data    <= '0;
            r_timer        <= '0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            // A response with no read outstanding is flagged and otherwise ignored.
            if (bus.resp_valid && (r_state != S_RD_WAIT))
                r_err_spurious <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.miss_valid) begin
                        r_miss_addr   <= bus.miss_block_addr;
                        r_victim_addr <= bus.victim_block_addr;
                        r_victim_data <= bus.victim_block_data;
                        r_state       <= bus.victim_dirty ? S_WB_REQ : S_RD_REQ;
                    end
                end
                S_WB_REQ: begin
                    if (bus.req_ready)
                        r_state <= S_RD_REQ;
                end
                S_RD_REQ: begin
                    if (bus.req_ready) begin
                        r_state <= S_RD_WAIT;
                        r_timer <= '0;
                    end
                end
                S_RD_WAIT: begin
                    if (bus.resp_valid) begin
                        r_resp_data <= bus.resp_block_data;
                        r_state     <= S_FILL;
                    end else if (r_timer != TMR_MAX) begin
                        // Timer parks at the limit; the flag marks it but we keep waiting.
                        r_timer <= r_timer + 1'b1;
                        if (r_timer == (TMR_MAX - 1'b1))
                            r_err_timeout <= 1'b1;
                    end
                end
                S_FILL:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    logic w_wb;
    logic w_rd;
    logic w_fill;

    assign w_wb   = (r_state == S_WB_REQ);
    assign w_rd   = (r_state == S_RD_REQ);
    assign w_fill = (r_state == S_FILL);

    assign bus.miss_ready      = (r_state == S_IDLE);
    assign bus.busy            = (r_state != S_IDLE);
    assign bus.req_valid       = w_wb | w_rd;
    assign bus.req_type        = w_wb ? REQ_WRITE : REQ_READ;
    assign bus.req_block_addr  = w_wb ? r_victim_addr : (w_rd ? r_miss_addr : '0);
    assign bus.req_block_data  = w_wb ? r_victim_data : '0;
    assign bus.fill_valid      = w_fill;
    assign bus.fill_block_addr = w_fill ? r_miss_addr : '0;
    assign bus.fill_block_data = w_fill ? r_resp_data : '0;
    assign bus.err_timeout     = r_err_timeout;
    assign bus.err_spurious    = r_err_spurious;
endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: clean and dirty misses, request backpressure,
// refill timeout, spurious response, back-to-back miss during fill, and mid-transaction reset.
module tb_dcache_miss_ctrl;
    localparam int AW = 16;
    localparam int DW = 64;

    logic clk;
    logic rst_aL;
    int   n_tests = 0;
    int   n_fail  = 0;

    dcache_miss_ctrl_if #(.BLOCK_ADDR_WIDTH(AW), .BLOCK_DATA_WIDTH(DW)) bus ();

    dcache_miss_ctrl #(
        .BLOCK_ADDR_WIDTH(AW),
        .BLOCK_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES  (8)
    ) u_dut (
        .clk   (clk),
        .rst_aL(rst_aL),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_aL                = 1'b0;
        bus.miss_valid        = 1'b0;
        bus.miss_block_addr   = '0;
        bus.victim_dirty      = 1'b0;
        bus.victim_block_addr = '0;
        bus.victim_block_data = '0;
        bus.req_ready         = 1'b0;
        bus.resp_valid        = 1'b0;
        bus.resp_block_data   = '0;
        step();
        step();

        // Reset state
        chk("rst_miss_ready", 64'(bus.miss_ready), 64'd1);
        chk("rst_busy",       64'(bus.busy), 64'd0);
        chk("rst_req_valid",  64'(bus.req_valid), 64'd0);
        chk("rst_fill_valid", 64'(bus.fill_valid), 64'd0);
        chk("rst_err_to",     64'(bus.err_timeout), 64'd0);
        chk("rst_err_sp",     64'(bus.err_spurious), 64'd0);
        rst_aL = 1'b1;
        step();

        // Clean miss 0x10, response three cycles after the read is accepted
        bus.miss_valid      = 1'b1;
        bus.miss_block_addr = 16'h0010;
        bus.victim_dirty    = 1'b0;
        bus.req_ready       = 1'b1;
        step();
        bus.miss_valid = 1'b0;
        chk("c_miss_ready", 64'(bus.miss_ready), 64'd0);
        chk("c_busy",       64'(bus.busy), 64'd1);
        chk("c_req_valid",  64'(bus.req_valid), 64'd1);
        chk("c_req_type",   64'(bus.req_type), 64'd0);
        chk("c_req_addr",   64'(bus.req_block_addr), 64'h10);
        chk("c_req_data",   bus.req_block_data, 64'd0);
        step();
        chk("c_wait_req_valid", 64'(bus.req_valid), 64'd0);
        step();
        step();
        bus.resp_valid      = 1'b1;
        bus.resp_block_data = 64'hA5A5_A5A5_A5A5_A5A5;
        chk("c_no_early_fill", 64'(bus.fill_valid), 64'd0);
        step();
        bus.resp_valid      = 1'b0;
        bus.resp_block_data = 64'h0;
        chk("c_fill_valid", 64'(bus.fill_valid), 64'd1);
        chk("c_fill_addr",  64'(bus.fill_block_addr), 64'h10);
        chk("c_fill_data",  bus.fill_block_data, 64'hA5A5_A5A5_A5A5_A5A5);
        step();
        chk("c_fill_pulse", 64'(bus.fill_valid), 64'd0);
        chk("c_fill_addr0", 64'(bus.fill_block_addr), 64'h0);
        chk("c_idle_ready", 64'(bus.miss_ready), 64'd1);

        // Dirty miss with req_ready held low for four cycles in writeback
        bus.miss_valid        = 1'b1;
        bus.miss_block_addr   = 16'h0010;
        bus.victim_dirty      = 1'b1;
        bus.victim_block_addr = 16'h0022;
        bus.victim_block_data = 64'h5A5A_5A5A_5A5A_5A5A;
        bus.req_ready         = 1'b0;
        step();
        bus.miss_valid        = 1'b0;
        bus.victim_block_addr = 16'hFFFF;
        bus.victim_block_data = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            chk("d_wb_valid", 64'(bus.req_valid), 64'd1);
            chk("d_wb_type",  64'(bus.req_type), 64'd1);
            chk("d_wb_addr",  64'(bus.req_block_addr), 64'h22);
            chk("d_wb_data",  bus.req_block_data, 64'h5A5A_5A5A_5A5A_5A5A);
            step();
        end
        bus.req_ready = 1'b1;
        chk("d_wb_hold_type", 64'(bus.req_type), 64'd1);
        step();
        chk("d_rd_valid", 64'(bus.req_valid), 64'd1);
        chk("d_rd_type",  64'(bus.req_type), 64'd0);
        chk("d_rd_addr",  64'(bus.req_block_addr), 64'h10);
        chk("d_rd_data",  bus.req_block_data, 64'd0);
        step();
        chk("d_wait_req_valid", 64'(bus.req_valid), 64'd0);
        bus.resp_valid      = 1'b1;
        bus.resp_block_data = 64'h0123_4567_89AB_CDEF;
        step();
        bus.resp_valid = 1'b0;
        chk("d_fill_valid", 64'(bus.fill_valid), 64'd1);
        chk("d_fill_addr",  64'(bus.fill_block_addr), 64'h10);
        chk("d_fill_data",  bus.fill_block_data, 64'h0123_4567_89AB_CDEF);
        step();
        chk("d_idle_busy", 64'(bus.busy), 64'd0);

        // Refill timeout at 8 RD_WAIT cycles, late response still fills
        bus.miss_valid      = 1'b1;
        bus.miss_block_addr = 16'h0033;
        bus.victim_dirty    = 1'b0;
        step();
        bus.miss_valid = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t_err_early", 64'(bus.err_timeout), 64'd0);
        end
        step();
        chk("t_err_set", 64'(bus.err_timeout), 64'd1);
        step();
        step();
        chk("t_busy_held", 64'(bus.busy), 64'd1);
        chk("t_no_retry",  64'(bus.req_valid), 64'd0);
        bus.resp_valid      = 1'b1;
        bus.resp_block_data = 64'h1111_2222_3333_4444;
        step();
        bus.resp_valid = 1'b0;
        chk("t_fill_valid", 64'(bus.fill_valid), 64'd1);
        chk("t_fill_addr",  64'(bus.fill_block_addr), 64'h33);
        chk("t_fill_data",  bus.fill_block_data, 64'h1111_2222_3333_4444);
        step();
        chk("t_err_sticky", 64'(bus.err_timeout), 64'd1);

        // Spurious response while idle, then a normal miss
        bus.resp_valid      = 1'b1;
        bus.resp_block_data = 64'h9999;
        step();
        bus.resp_valid = 1'b0;
        chk("s_err",        64'(bus.err_spurious), 64'd1);
        chk("s_fill_valid", 64'(bus.fill_valid), 64'd0);
        chk("s_busy",       64'(bus.busy), 64'd0);
        chk("s_miss_ready", 64'(bus.miss_ready), 64'd1);
        bus.miss_valid      = 1'b1;
        bus.miss_block_addr = 16'h0044;
        step();
        bus.miss_valid = 1'b0;
        chk("s_req_addr", 64'(bus.req_block_addr), 64'h44);
        step();
        bus.resp_valid      = 1'b1;
        bus.resp_block_data = 64'hCAFE_F00D_CAFE_F00D;
        step();
        bus.resp_valid = 1'b0;
        chk("s_fill_addr", 64'(bus.fill_block_addr), 64'h44);
        chk("s_fill_data", bus.fill_block_data, 64'hCAFE_F00D_CAFE_F00D);

        // Miss presented during FILL waits for the following IDLE cycle
        bus.miss_valid      = 1'b1;
        bus.miss_block_addr = 16'h0055;
        chk("f_ready_in_fill", 64'(bus.miss_ready), 64'd0);
        step();
        chk("f_idle_busy",  64'(bus.busy), 64'd0);
        chk("f_idle_ready", 64'(bus.miss_ready), 64'd1);
        step();
        bus.miss_valid = 1'b0;
        chk("f_req_addr", 64'(bus.req_block_addr), 64'h55);
        step();

        // Reset asserted during RD_WAIT drops the transaction
        chk("r_in_wait", 64'(bus.busy), 64'd1);
        chk("r_err_before", 64'(bus.err_timeout), 64'd1);
        #2 rst_aL = 1'b0;
        #1;
        chk("r_busy",       64'(bus.busy), 64'd0);
        chk("r_miss_ready", 64'(bus.miss_ready), 64'd1);
        chk("r_req_valid",  64'(bus.req_valid), 64'd0);
        chk("r_fill_valid", 64'(bus.fill_valid), 64'd0);
        chk("r_err_to",     64'(bus.err_timeout), 64'd0);
        chk("r_err_sp",     64'(bus.err_spurious), 64'd0);
        step();
        step();
        rst_aL = 1'b1;
        bus.resp_valid      = 1'b1;
        bus.resp_block_data = 64'h7777;
        step();
        bus.resp_valid = 1'b0;
        chk("r_post_fill", 64'(bus.fill_valid), 64'd0);
        chk("r_post_busy", 64'(bus.busy), 64'd0);
        chk("r_post_sp",   64'(bus.err_spurious), 64'd1);
        step();
        chk("r_post_fill2", 64'(bus.fill_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
